secded_check_pipe: RTL and testbench

- Parametrised, pipelined SEC-DED (extended Hamming) checker for the protected datapath.
- Accepts a data word plus its check bits over a valid/ready handshake. Corrects any single-bit error and flags double-bit errors, with two registered stages.
- Keeps saturating error counters and a first-uncorrectable-error log. It sits between protected storage (register file, memories) and its consumers, and replaces the fixed 11-bit combinational decoder.

---
 rtl/secded_pkg.sv | 41 ++++
 rtl/secded_check_pipe_if.sv | 34 +++
 rtl/secded_syndrome.sv | 22 ++
 rtl/secded_check_pipe.sv | 135 +++++++++++++
 tb/tb_secded_check_pipe.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared SEC-DED helpers for the checker and the matching encoder
package secded_pkg;

    typedef enum logic [1:0] {
        CLEAN,
        SEC_DATA,
        SEC_CHK,
        DED
    } err_class_e;

    // Smallest r with 2^r >= data_w + r + 1; the overall parity bit is extra.
    function automatic int calc_chk_w(input int data_w);
        int r = 0;
        while ((1 << r) < data_w + r + 1) r++;
        return r;
    endfunction

    // Data bits covered by check bit k (positions 1-based, data fills non-powers of two).
    function automatic logic [63:0] chk_mask(input int k, input int data_w);
        logic [63:0] mask = '0;
        int idx = 0;
        for (int p = 1; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (idx < data_w && ((p >> k) & 1) == 1) mask = mask | (64'd1 << idx);
                idx++;
            end
        end
        return mask;
    endfunction

    // Codeword position to data index; -1 for zero or a check-bit position.
    function automatic int pos_to_idx(input int pos);
        int l = 0;
        if (pos <= 0 || (pos & (pos - 1)) == 0) return -1;
        for (int b = 0; b < 31; b++) begin
            if ((pos >> b) != 0) l = b;
        end
        return pos - l - 2;
    endfunction

endpackage

// File: rtl/secded_check_pipe_if.sv
// rtl/secded_check_pipe_if.sv - input/output beat handshake bundle of the SEC-DED checker
interface secded_check_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
);
    import secded_pkg::*;

    localparam int CHK_W = calc_chk_w(DATA_W);
    localparam int PAR_W = CHK_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PAR_W-1:0]  in_parity;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_sec;
    logic              out_ded;
    logic [CHK_W-1:0]  out_syndrome;

    modport master (
        output in_valid, in_data, in_parity, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_sec, out_ded, out_syndrome
    );

    modport slave (
        input  in_valid, in_data, in_parity, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_sec, out_ded, out_syndrome
    );

endinterface

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational syndrome and overall-parity mismatch (also used as encoder)
module secded_syndrome
    import secded_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = calc_chk_w(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W:0]    parity,
    output logic [CHK_W-1:0]  syndrome,
    output logic              mismatch
);

    // With parity forced to zero the syndrome output is the encoder's check bits.
    for (genvar k = 0; k < CHK_W; k++) begin : g_chk
        localparam logic [63:0] MASK = chk_mask(k, DATA_W);
        assign syndrome[k] = parity[k] ^ (^(data & MASK[DATA_W-1:0]));
    end

    assign mismatch = (^data) ^ (^parity);

endmodule

// File: rtl/secded_check_pipe.sv
// rtl/secded_check_pipe.sv - two-stage SEC-DED checker; stats/log built only with SECDED_STATS_EN
module secded_check_pipe
    import secded_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    secded_check_pipe_if.slave bus,
    input  logic               clr_stats,
    output logic [CNT_W-1:0]   sec_count,
    output logic [CNT_W-1:0]   ded_count,
    output logic               ded_log_valid,
    output logic [TAG_W-1:0]   ded_log_tag
);

    localparam int CHK_W = calc_chk_w(DATA_W);
    localparam logic [CHK_W-1:0] LAST_POS = CHK_W'(DATA_W + CHK_W);

    logic [CHK_W-1:0]  in_syn;
    logic              in_m;
    logic              s1_full;
    logic [DATA_W-1:0] s1_data;
    logic [TAG_W-1:0]  s1_tag;
    logic [CHK_W-1:0]  s1_syn;
    logic              s1_m;
    logic              s1_load, s1_moves, s2_load, s2_moves;
    err_class_e        cls;
    int                dec_idx;
    logic [DATA_W-1:0] flip;

    secded_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syndrome (
        .data     (bus.in_data),
        .parity   (bus.in_parity),
        .syndrome (in_syn),
        .mismatch (in_m)
    );

    assign s2_moves     = bus.out_valid & bus.out_ready;
    assign s2_load      = !bus.out_valid || s2_moves;
    assign s1_moves     = s1_full & s2_load;
    assign bus.in_ready = !s1_full || s1_moves;
    assign s1_load      = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_data <= '0;
            s1_tag  <= '0;
            s1_syn  <= '0;
            s1_m    <= 1'b0;
        end else if (s1_load) begin
            s1_full <= 1'b1;
            s1_data <= bus.in_data;
            s1_tag  <= bus.in_tag;
            s1_syn  <= in_syn;
            s1_m    <= in_m;
        end else if (s1_moves) begin
            s1_full <= 1'b0;
        end
    end

    // A zero syndrome with m=1 is the overall bit, so it joins the check-bit class.
    always_comb begin
        cls = CLEAN;
        if (!s1_m) begin
            cls = (s1_syn == '0) ? CLEAN : DED;
        end else if ((s1_syn & (s1_syn - CHK_W'(1))) == '0) begin
            cls = SEC_CHK;
        end else if (s1_syn > LAST_POS) begin
            cls = DED;
        end else begin
            cls = SEC_DATA;
        end
    end

    assign dec_idx = pos_to_idx(int'(s1_syn));

    for (genvar i = 0; i < DATA_W; i++) begin : g_flip
        assign flip[i] = (cls == SEC_DATA) && (dec_idx == i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_tag      <= '0;
            bus.out_syndrome <= '0;
            bus.out_sec      <= 1'b0;
            bus.out_ded      <= 1'b0;
        end else if (s2_load) begin
            bus.out_valid <= s1_full;
            if (s1_full) begin
                bus.out_data     <= s1_data ^ flip;
                bus.out_tag      <= s1_tag;
                bus.out_syndrome <= s1_syn;
                bus.out_sec      <= (cls == SEC_DATA) || (cls == SEC_CHK);
                bus.out_ded      <= (cls == DED);
            end
        end
    end

`ifdef SECDED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_count     <= '0;
            ded_count     <= '0;
            ded_log_valid <= 1'b0;
            ded_log_tag   <= '0;
        end else if (clr_stats) begin
            sec_count     <= '0;
            ded_count     <= '0;
            ded_log_valid <= 1'b0;
            ded_log_tag   <= '0;
        end else if (s2_moves) begin
            if (bus.out_sec && sec_count != '1) sec_count <= sec_count + CNT_W'(1);
            if (bus.out_ded && ded_count != '1) ded_count <= ded_count + CNT_W'(1);
            if (bus.out_ded && !ded_log_valid) begin
                ded_log_valid <= 1'b1;
                ded_log_tag   <= bus.out_tag;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats  = clr_stats;
    assign sec_count     = '0;
    assign ded_count     = '0;
    assign ded_log_valid = 1'b0;
    assign ded_log_tag   = '0;
`endif

endmodule

// File: tb/tb_secded_check_pipe.sv
// tb/tb_secded_check_pipe.sv - directed self-checking bench for secded_check_pipe
module tb_secded_check_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clr_a, clr_b;
    logic [15:0] sec_a, ded_a;
    logic        logv_a;
    logic [7:0]  logt_a;
    logic [1:0]  sec_b, ded_b;
    logic        logv_b;
    logic [7:0]  logt_b;

    secded_check_pipe_if #(.DATA_W(32), .TAG_W(8)) bus_a ();
    secded_check_pipe_if #(.DATA_W(32), .TAG_W(8)) bus_b ();

    secded_check_pipe #(.DATA_W(32), .TAG_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .clr_stats(clr_a),
        .sec_count(sec_a), .ded_count(ded_a), .ded_log_valid(logv_a), .ded_log_tag(logt_a)
    );

    secded_check_pipe #(.DATA_W(32), .TAG_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .clr_stats(clr_b),
        .sec_count(sec_b), .ded_count(ded_b), .ded_log_valid(logv_b), .ded_log_tag(logt_b)
    );

`ifdef SECDED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] st(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    // Independent reference encoder: lay out the codeword, then compute even parities.
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [38:0] cw;
        logic [6:0]  p;
        int          idx;
        cw  = '0;
        p   = '0;
        idx = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[idx];
                idx++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            for (int pos = 1; pos <= 38; pos++) begin
                if (((pos >> k) & 1) == 1) p[k] = p[k] ^ cw[pos];
            end
        end
        p[6] = (^d) ^ (^p[5:0]);
        return p;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic [6:0] p, input logic [7:0] t);
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = d;
        bus_a.in_parity = p;
        bus_a.in_tag    = t;
        tick();
        bus_a.in_valid = 1'b0;
        tick();
    endtask

    task automatic send_b(input logic [31:0] d, input logic [6:0] p, input logic [7:0] t);
        bus_b.in_valid  = 1'b1;
        bus_b.in_data   = d;
        bus_b.in_parity = p;
        bus_b.in_tag    = t;
        tick();
        bus_b.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] w;
    logic [6:0]  p0;
    logic [31:0] bd [3];
    logic [7:0]  bt [3];
    logic [31:0] rx_d [3];
    logic [7:0]  rx_t [3];
    int          acc, got;
    logic        rdy;

    initial begin
        w  = 32'hDEADBEEF;
        p0 = enc(w);
        bd[0] = 32'h11111111; bt[0] = 8'hA0;
        bd[1] = 32'h22222222; bt[1] = 8'hA1;
        bd[2] = 32'h33333333; bt[2] = 8'hA2;

        rst_n = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_parity = '0; bus_a.in_tag = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_parity = '0; bus_b.in_tag = '0;
        bus_b.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        check("rst_out_data", 64'(bus_a.out_data), 64'd0);
        check("rst_out_tag", 64'(bus_a.out_tag), 64'd0);
        check("rst_syndrome", 64'(bus_a.out_syndrome), 64'd0);
        check("rst_sec_ded", 64'({bus_a.out_sec, bus_a.out_ded}), 64'd0);
        check("rst_counts", 64'({sec_a, ded_a}), 64'd0);
        check("rst_log", 64'({logv_a, logt_a}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Clean word, 2-cycle latency
        send_a(w, p0, 8'h01);
        check("clean_valid", 64'(bus_a.out_valid), 64'd1);
        check("clean_data", 64'(bus_a.out_data), 64'hDEADBEEF);
        check("clean_flags", 64'({bus_a.out_sec, bus_a.out_ded}), 64'd0);
        check("clean_syn", 64'(bus_a.out_syndrome), 64'd0);
        check("clean_tag", 64'(bus_a.out_tag), 64'h01);
        tick();
        check("clean_drain", 64'(bus_a.out_valid), 64'd0);

        // Data bit 5 (position 10)
        send_a(w ^ 32'h20, p0, 8'h02);
        check("sec5_data", 64'(bus_a.out_data), 64'hDEADBEEF);
        check("sec5_flags", 64'({bus_a.out_sec, bus_a.out_ded}), 64'b10);
        check("sec5_syn", 64'(bus_a.out_syndrome), 64'd10);
        tick();
        check("sec5_count", 64'(sec_a), st(1));

        // Data bits 0,1 (positions 3,5): syndrome 6, m=0
        send_a(w ^ 32'h3, p0, 8'h3C);
        check("ded01_flags", 64'({bus_a.out_sec, bus_a.out_ded}), 64'b01);
        check("ded01_data", 64'(bus_a.out_data), 64'hDEADBEEC);
        check("ded01_syn", 64'(bus_a.out_syndrome), 64'd6);
        tick();
        check("ded01_logv", 64'(logv_a), st(1));
        check("ded01_logt", 64'(logt_a), st(8'h3C));
        check("ded01_count", 64'(ded_a), st(1));

        // Data bits 2,3 (positions 6,7): second DED must not overwrite the log
        send_a(w ^ 32'hC, p0, 8'h11);
        check("ded23_flags", 64'({bus_a.out_sec, bus_a.out_ded}), 64'b01);
        check("ded23_syn", 64'(bus_a.out_syndrome), 64'd1);
        tick();
        check("ded23_logt", 64'(logt_a), st(8'h3C));
        check("ded23_count", 64'(ded_a), st(2));

        // Overall parity bit only
        send_a(w, p0 ^ 7'h40, 8'h04);
        check("ovr_flags", 64'({bus_a.out_sec, bus_a.out_ded}), 64'b10);
        check("ovr_data", 64'(bus_a.out_data), 64'hDEADBEEF);
        check("ovr_syn", 64'(bus_a.out_syndrome), 64'd0);
        tick();

        // Check bit 2 (position 4)
        send_a(w, p0 ^ 7'h04, 8'h05);
        check("chk2_flags", 64'({bus_a.out_sec, bus_a.out_ded}), 64'b10);
        check("chk2_data", 64'(bus_a.out_data), 64'hDEADBEEF);
        check("chk2_syn", 64'(bus_a.out_syndrome), 64'd4);
        tick();

        // Last valid position 38 = data bit 31
        send_a(w ^ 32'h80000000, p0, 8'h06);
        check("d31_flags", 64'({bus_a.out_sec, bus_a.out_ded}), 64'b10);
        check("d31_data", 64'(bus_a.out_data), 64'hDEADBEEF);
        check("d31_syn", 64'(bus_a.out_syndrome), 64'd38);
        tick();

        // Three flips giving syndrome 39 with m=1: beyond last position
        send_a(w ^ 32'h8, p0 ^ 7'h60, 8'h07);
        check("beyond_flags", 64'({bus_a.out_sec, bus_a.out_ded}), 64'b01);
        check("beyond_data", 64'(bus_a.out_data), 64'hDEADBEE7);
        check("beyond_syn", 64'(bus_a.out_syndrome), 64'd39);
        tick();
        check("a_sec_total", 64'(sec_a), st(4));
        check("a_ded_total", 64'(ded_a), st(3));
        check("a_logt_final", 64'(logt_a), st(8'h3C));

        // Backpressure: 3 beats offered while out_ready=0
        bus_a.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            bus_a.in_valid  = 1'b1;
            bus_a.in_data   = bd[acc];
            bus_a.in_parity = enc(bd[acc]);
            bus_a.in_tag    = bt[acc];
            #1;
            rdy = bus_a.in_ready;
            @(posedge clk);
            if (rdy) acc++;
            #1;
        end
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("bp_hold_valid", 64'(bus_a.out_valid), 64'd1);
        check("bp_hold_data", 64'(bus_a.out_data), 64'h11111111);
        check("bp_hold_tag", 64'(bus_a.out_tag), 64'hA0);

        bus_a.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            bus_a.in_valid = (acc < 3);
            if (acc < 3) begin
                bus_a.in_data   = bd[acc];
                bus_a.in_parity = enc(bd[acc]);
                bus_a.in_tag    = bt[acc];
            end
            #1;
            rdy = bus_a.in_ready;
            if (bus_a.out_valid) begin
                if (got < 3) begin
                    rx_d[got] = bus_a.out_data;
                    rx_t[got] = bus_a.out_tag;
                end
                got++;
            end
            @(posedge clk);
            if (bus_a.in_valid && rdy) acc++;
            #1;
        end
        bus_a.in_valid = 1'b0;
        check("bp_total_in", 64'(acc), 64'd3);
        check("bp_total_out", 64'(got), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got) begin
                check($sformatf("bp_order_data%0d", i), 64'(rx_d[i]), 64'(bd[i]));
                check($sformatf("bp_order_tag%0d", i), 64'(rx_t[i]), 64'(bt[i]));
            end
        end

        // CNT_W=2 saturation: 5 SEC beats
        for (int i = 0; i < 5; i++) begin
            send_b(w ^ 32'h20, p0, 8'h20);
            check($sformatf("b_sec%0d", i), 64'(bus_b.out_sec), 64'd1);
            tick();
        end
        check("b_sec_sat", 64'(sec_b), st(3));

        send_b(w ^ 32'h3, p0, 8'h3C);
        tick();
        check("b_ded_one", 64'(ded_b), st(1));
        check("b_logv_one", 64'(logv_b), st(1));

        // clr_stats on the same cycle as a DED transfer
        send_b(w ^ 32'h3, p0, 8'h55);
        check("b_clr_ded_present", 64'({bus_b.out_valid, bus_b.out_ded}), 64'b11);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        check("b_clr_ded_count", 64'(ded_b), 64'd0);
        check("b_clr_logv", 64'(logv_b), 64'd0);
        check("b_clr_logt", 64'(logt_b), 64'd0);
        check("b_clr_sec_count", 64'(sec_b), 64'd0);

        // Reset with beats in flight
        bus_b.in_valid  = 1'b1;
        bus_b.in_data   = w;
        bus_b.in_parity = p0;
        bus_b.in_tag    = 8'h77;
        tick();
        tick();
        check("rst_inflight_pre", 64'(bus_b.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(bus_b.out_valid), 64'd0);
        check("rst_async_ready", 64'(bus_b.in_ready), 64'd1);
        check("rst_async_data", 64'(bus_b.out_data), 64'd0);
        bus_b.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_discarded", 64'(bus_b.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
